// File: rtl/branch_predictor_gshare.sv
// Gshare branch predictor: a saturating-counter PHT indexed by PC xor global history,
// a tagged BTB, and a speculative GHR that is repaired from the carried snapshot on a flush.
module branch_predictor_gshare #(
  parameter int PHT_BITS  = 8,
  parameter int BTB_BITS  = 6,
  parameter int TAG_BITS  = 10,
  parameter int CTR_BITS  = 2,
  parameter int GHR_BITS  = 8,
  parameter int GSHARE_EN = 1
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                fetch_valid_i,
  input  logic [31:0]         fetch_pc_i,
  output logic                fetch_hit_o,
  output logic                fetch_predict_o,
  output logic [31:0]         fetch_target_o,
  output logic [GHR_BITS-1:0] fetch_ghr_o,
  input  logic                mem_branch_i,
  input  logic [31:0]         mem_pc_i,
  input  logic                mem_taken_i,
  input  logic [31:0]         mem_target_res_i,
  input  logic                mem_predict_i,
  input  logic [31:0]         mem_target_i,
  input  logic [GHR_BITS-1:0] mem_ghr_i,
  output logic                mem_flush_o
);

  localparam int PHT_N = 1 << PHT_BITS;
  localparam int BTB_N = 1 << BTB_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic [CTR_BITS-1:0] pht_q       [PHT_N];
  logic                btb_valid_q [BTB_N];
  logic [TAG_BITS-1:0] btb_tag_q   [BTB_N];
  logic [31:0]         btb_tgt_q   [BTB_N];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;

  logic [PHT_BITS-1:0] f_idx, m_idx;
  logic [BTB_BITS-1:0] f_bidx, m_bidx;
  logic [TAG_BITS-1:0] f_tag, m_tag;
  logic                f_hit, f_pred, flush;
  logic [CTR_BITS-1:0] ctr_cur, ctr_d;
  logic                unused_pc;

  assign f_bidx = fetch_pc_i[BTB_BITS+1:2];
  assign m_bidx = mem_pc_i[BTB_BITS+1:2];
  assign f_tag  = fetch_pc_i[BTB_BITS+TAG_BITS+1:BTB_BITS+2];
  assign m_tag  = mem_pc_i[BTB_BITS+TAG_BITS+1:BTB_BITS+2];

  // Resolution indexes with the history the branch was predicted under, never the live GHR.
  assign f_idx = (GSHARE_EN != 0) ? (fetch_pc_i[PHT_BITS+1:2] ^ PHT_BITS'(ghr_q))
                                  : fetch_pc_i[PHT_BITS+1:2];
  assign m_idx = (GSHARE_EN != 0) ? (mem_pc_i[PHT_BITS+1:2] ^ PHT_BITS'(mem_ghr_i))
                                  : mem_pc_i[PHT_BITS+1:2];

  // Interface contract: the fetch lookup is always live and fetch_valid_i only qualifies
  // GHR speculation; mem_branch_i is a one-cycle strobe with no backpressure.
  assign f_hit  = btb_valid_q[f_bidx] && (btb_tag_q[f_bidx] == f_tag);
  assign f_pred = f_hit && pht_q[f_idx][CTR_BITS-1];
  assign flush  = nrst && mem_branch_i &&
                  (mem_predict_i ? (!mem_taken_i || (mem_target_res_i != mem_target_i))
                                 : mem_taken_i);

  assign fetch_hit_o     = f_hit;
  assign fetch_predict_o = f_pred;
  assign fetch_target_o  = btb_tgt_q[f_bidx];
  assign fetch_ghr_o     = ghr_q;
  assign mem_flush_o     = flush;

  assign unused_pc = ^{fetch_pc_i, mem_pc_i};

  always_comb begin
    ctr_cur = pht_q[m_idx];
    ctr_d   = ctr_cur;
    if (mem_taken_i) begin
      if (ctr_cur != CTR_MAX) ctr_d = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != '0) ctr_d = ctr_cur - 1'b1;
    end
  end

  // Recovery outranks same-cycle speculation; the truncating cast drops the oldest bit.
  always_comb begin
    ghr_d = ghr_q;
    if (flush) ghr_d = GHR_BITS'({mem_ghr_i, mem_taken_i});
    else if (fetch_valid_i && f_hit) ghr_d = GHR_BITS'({ghr_q, f_pred});
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= '0;
    end else if (mem_branch_i) begin
      pht_q[m_idx] <= ctr_d;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < BTB_N; i++) begin
        btb_valid_q[i] <= 1'b0;
        btb_tag_q[i]   <= '0;
        btb_tgt_q[i]   <= '0;
      end
    end else if (mem_branch_i && mem_taken_i) begin
      btb_valid_q[m_bidx] <= 1'b1;
      btb_tag_q[m_bidx]   <= m_tag;
      btb_tgt_q[m_bidx]   <= mem_target_res_i;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Bench for branch_predictor_gshare: a default gshare instance checked against a behavioural
// model plus directed cases, and a bimodal 1-bit-history 1-bit-counter instance.
module tb_branch_predictor_gshare;

  logic        clk, nrst;
  logic        fetch_valid, fetch_hit, fetch_predict, mem_branch, mem_taken, mem_predict, mem_flush;
  logic [31:0] fetch_pc, fetch_target, mem_pc, mem_target_res, mem_target;
  logic [7:0]  fetch_ghr, mem_ghr;

  logic        b_fetch_valid, b_fetch_hit, b_fetch_predict, b_mem_branch, b_mem_taken;
  logic        b_mem_predict, b_mem_flush, b_fetch_ghr, b_mem_ghr;
  logic [31:0] b_fetch_pc, b_fetch_target, b_mem_pc, b_mem_target_res, b_mem_target;

  logic [31:0] exp_q[$];
  int          n_checks, n_pass;

  logic [1:0]  m_pht [256];
  logic        m_v   [64];
  logic [9:0]  m_tag [64];
  logic [31:0] m_tgt [64];
  logic [7:0]  m_ghr;

  branch_predictor_gshare dut (
    .clk(clk), .nrst(nrst),
    .fetch_valid_i(fetch_valid), .fetch_pc_i(fetch_pc), .fetch_hit_o(fetch_hit),
    .fetch_predict_o(fetch_predict), .fetch_target_o(fetch_target), .fetch_ghr_o(fetch_ghr),
    .mem_branch_i(mem_branch), .mem_pc_i(mem_pc), .mem_taken_i(mem_taken),
    .mem_target_res_i(mem_target_res), .mem_predict_i(mem_predict), .mem_target_i(mem_target),
    .mem_ghr_i(mem_ghr), .mem_flush_o(mem_flush)
  );

  branch_predictor_gshare #(.GSHARE_EN(0), .GHR_BITS(1), .CTR_BITS(1)) dut_b (
    .clk(clk), .nrst(nrst),
    .fetch_valid_i(b_fetch_valid), .fetch_pc_i(b_fetch_pc), .fetch_hit_o(b_fetch_hit),
    .fetch_predict_o(b_fetch_predict), .fetch_target_o(b_fetch_target), .fetch_ghr_o(b_fetch_ghr),
    .mem_branch_i(b_mem_branch), .mem_pc_i(b_mem_pc), .mem_taken_i(b_mem_taken),
    .mem_target_res_i(b_mem_target_res), .mem_predict_i(b_mem_predict), .mem_target_i(b_mem_target),
    .mem_ghr_i(b_mem_ghr), .mem_flush_o(b_mem_flush)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic sb_push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got 0x%0h expected <empty queue>", tag, got);
    end else begin
      check(tag, got, exp_q.pop_front());
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_pht[i] = 2'd0;
    for (int i = 0; i < 64; i++) begin
      m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0;
    end
    m_ghr = '0;
  endtask

  // driver tasks
  task automatic drive_mem(input logic [31:0] pc, input logic tk, input logic [31:0] res,
                           input logic pr, input logic [31:0] tg, input logic [7:0] g);
    mem_branch = 1'b1; mem_pc = pc; mem_taken = tk; mem_target_res = res;
    mem_predict = pr; mem_target = tg; mem_ghr = g;
  endtask

  task automatic drive_b_mem(input logic [31:0] pc, input logic tk, input logic [31:0] res,
                             input logic pr, input logic [31:0] tg, input logic g);
    b_mem_branch = 1'b1; b_mem_pc = pc; b_mem_taken = tk; b_mem_target_res = res;
    b_mem_predict = pr; b_mem_target = tg; b_mem_ghr = g;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Compares the main instance against the model, then steps model and DUT one cycle.
  task automatic advance();
    logic [5:0] bi;
    logic [7:0] pi, mi;
    logic [1:0] c;
    logic       e_hit, e_pred, e_flush;
    bi      = fetch_pc[7:2];
    e_hit   = m_v[bi] && (m_tag[bi] == fetch_pc[17:8]);
    pi      = fetch_pc[9:2] ^ m_ghr;
    e_pred  = e_hit && m_pht[pi][1];
    e_flush = mem_branch && (mem_predict ? (!mem_taken || (mem_target_res != mem_target)) : mem_taken);
    sb_push({31'd0, e_hit});
    sb_push({31'd0, e_pred});
    sb_push(m_tgt[bi]);
    sb_push({24'd0, m_ghr});
    sb_push({31'd0, e_flush});
    sb_pop("model_hit", fetch_hit);
    sb_pop("model_predict", fetch_predict);
    sb_pop("model_target", fetch_target);
    sb_pop("model_ghr", fetch_ghr);
    sb_pop("model_flush", mem_flush);
    if (mem_branch) begin
      mi = mem_pc[9:2] ^ mem_ghr;
      c  = m_pht[mi];
      if (mem_taken) begin
        if (c != 2'd3) c = c + 2'd1;
      end else if (c != 2'd0) begin
        c = c - 2'd1;
      end
      m_pht[mi] = c;
      if (mem_taken) begin
        m_v[mem_pc[7:2]]   = 1'b1;
        m_tag[mem_pc[7:2]] = mem_pc[17:8];
        m_tgt[mem_pc[7:2]] = mem_target_res;
      end
    end
    if (e_flush) m_ghr = {mem_ghr[6:0], mem_taken};
    else if (fetch_valid && e_hit) m_ghr = {m_ghr[6:0], e_pred};
    tick();
  endtask

  function automatic logic [31:0] pick_pc();
    logic [31:0] pc;
    pc = 32'h100 + (32'($urandom_range(0, 15)) << 2);
    if ($urandom_range(0, 3) == 0) pc = pc + 32'h100;
    return pc;
  endfunction

  initial begin
    n_checks = 0; n_pass = 0;
    nrst = 1'b0;
    fetch_valid = 0; fetch_pc = 32'h100; mem_branch = 0; mem_pc = 0; mem_taken = 0;
    mem_target_res = 0; mem_predict = 0; mem_target = 0; mem_ghr = 0;
    b_fetch_valid = 0; b_fetch_pc = 32'h100; b_mem_branch = 0; b_mem_pc = 0; b_mem_taken = 0;
    b_mem_target_res = 0; b_mem_predict = 0; b_mem_target = 0; b_mem_ghr = 0;
    model_reset();
    repeat (2) @(negedge clk);

    // Outputs held at zero in reset, even with a flush-shaped resolution presented.
    drive_mem(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 8'h00);
    for (int i = 0; i < 5; i++) sb_push(32'h0);
    settle();
    sb_pop("rst_hit", fetch_hit);
    sb_pop("rst_predict", fetch_predict);
    sb_pop("rst_target", fetch_target);
    sb_pop("rst_ghr", fetch_ghr);
    sb_pop("rst_flush", mem_flush);
    mem_branch = 0;
    nrst = 1'b1;
    @(negedge clk);

    fetch_valid = 1; fetch_pc = 32'h100;
    settle(); advance();

    // First taken resolution of an unpredicted branch.
    fetch_valid = 0;
    drive_mem(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 8'h00);
    sb_push(32'h1);
    settle(); sb_pop("tp2_flush", mem_flush); advance();

    mem_branch = 0;
    sb_push(32'h1); sb_push(32'h200); sb_push(32'h01); sb_push(32'h0);
    settle();
    sb_pop("tp2_hit", fetch_hit);
    sb_pop("tp2_target", fetch_target);
    sb_pop("tp2_ghr", fetch_ghr);
    sb_pop("tp2_pred_ghr1", fetch_predict);
    advance();

    drive_mem(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 8'h00);
    settle(); advance();
    drive_mem(32'h400, 1'b0, 32'h0, 1'b1, 32'h404, 8'h00);
    settle(); advance();

    mem_branch = 0;
    sb_push(32'h1); sb_push(32'h0);
    settle();
    sb_pop("tp2_pred_ctr2", fetch_predict);
    sb_pop("tp2_ghr_restored", fetch_ghr);
    advance();

    for (int i = 0; i < 3; i++) begin
      drive_mem(32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 8'h00);
      sb_push(32'h0);
      settle(); sb_pop("tp2_correct_flush", mem_flush); advance();
    end
    // One not-taken after five taken: a saturated counter still predicts taken.
    drive_mem(32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 8'h00);
    settle(); advance();
    mem_branch = 0;
    sb_push(32'h1);
    settle(); sb_pop("tp2_saturation", fetch_predict); advance();

    // BTB alias with a taken counter selected through history 0xC0.
    drive_mem(32'h400, 1'b0, 32'h0, 1'b1, 32'h404, 8'h60);
    settle(); advance();
    mem_branch = 0; fetch_pc = 32'h200;
    sb_push(32'h0); sb_push(32'h0); sb_push(32'h200); sb_push(32'hC0);
    settle();
    sb_pop("tp3_alias_hit", fetch_hit);
    sb_pop("tp3_alias_pred", fetch_predict);
    sb_pop("tp3_alias_target", fetch_target);
    sb_pop("tp3_ghr", fetch_ghr);
    advance();

    fetch_pc = 32'h100;
    drive_mem(32'h100, 1'b1, 32'h300, 1'b1, 32'h200, 8'h03);
    sb_push(32'h1);
    settle(); sb_pop("tp4_flush", mem_flush); advance();
    mem_branch = 0;
    sb_push(32'h300); sb_push(32'h07); sb_push(32'h1);
    settle();
    sb_pop("tp4_target", fetch_target);
    sb_pop("tp4_ghr", fetch_ghr);
    sb_pop("tp4_hit", fetch_hit);
    advance();

    drive_mem(32'h400, 1'b0, 32'h0, 1'b1, 32'h404, 8'h55);
    settle(); advance();
    fetch_valid = 1;
    drive_mem(32'h400, 1'b0, 32'h0, 1'b1, 32'h404, 8'h0F);
    sb_push(32'hAA); sb_push(32'h1); sb_push(32'h1);
    settle();
    sb_pop("tp5_ghr_before", fetch_ghr);
    sb_pop("tp5_hit", fetch_hit);
    sb_pop("tp5_flush", mem_flush);
    advance();
    fetch_valid = 0;
    drive_mem(32'h100, 1'b1, 32'h300, 1'b1, 32'h300, 8'h1E);
    sb_push(32'h1E); sb_push(32'h0);
    settle();
    sb_pop("tp5_recovery_wins", fetch_ghr);
    sb_pop("tp5_correct_noflush", mem_flush);
    advance();
    mem_branch = 0;
    sb_push(32'h1E);
    settle(); sb_pop("tp5_ghr_unchanged", fetch_ghr); advance();
    fetch_valid = 1;
    settle(); advance();
    fetch_valid = 0;
    sb_push(32'h3C);
    settle(); sb_pop("spec_shift", fetch_ghr); advance();

    for (int k = 0; k < 400; k++) begin
      fetch_valid = 1'($urandom_range(0, 1));
      fetch_pc = pick_pc();
      if ($urandom_range(0, 2) == 0)
        drive_mem(pick_pc(), 1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 3)) * 4,
                  1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 3)) * 4,
                  8'($urandom_range(0, 255)));
      else mem_branch = 0;
      settle(); advance();
    end

    // Reset asserted mid-operation with a live hit and a flush-shaped resolution.
    fetch_valid = 1; fetch_pc = 32'h100;
    drive_mem(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 8'h00);
    settle(); advance();
    settle();
    nrst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) sb_push(32'h0);
    #1;
    sb_pop("midrst_hit", fetch_hit);
    sb_pop("midrst_predict", fetch_predict);
    sb_pop("midrst_target", fetch_target);
    sb_pop("midrst_ghr", fetch_ghr);
    sb_pop("midrst_flush", mem_flush);
    mem_branch = 0; fetch_valid = 0;
    @(negedge clk);
    nrst = 1'b1;
    settle(); advance();

    // Bimodal, 1-bit history, 1-bit counter instance.
    b_fetch_pc = 32'h100; b_fetch_valid = 0;
    sb_push(32'h0); sb_push(32'h0); sb_push(32'h0);
    settle();
    sb_pop("b_rst_hit", b_fetch_hit);
    sb_pop("b_rst_pred", b_fetch_predict);
    sb_pop("b_rst_ghr", b_fetch_ghr);
    tick();
    drive_b_mem(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    sb_push(32'h1);
    settle(); sb_pop("b_flush_taken", b_mem_flush); tick();
    b_mem_branch = 0;
    sb_push(32'h1); sb_push(32'h1); sb_push(32'h1); sb_push(32'h200);
    settle();
    sb_pop("b_hit", b_fetch_hit);
    sb_pop("b_pred_ctr1", b_fetch_predict);
    sb_pop("b_ghr1", b_fetch_ghr);
    sb_pop("b_target", b_fetch_target);
    tick();
    drive_b_mem(32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
    sb_push(32'h1);
    settle(); sb_pop("b_flush_nt", b_mem_flush); tick();
    b_mem_branch = 0;
    sb_push(32'h1); sb_push(32'h0); sb_push(32'h0);
    settle();
    sb_pop("b_hit_after_nt", b_fetch_hit);
    sb_pop("b_single_nt_flip", b_fetch_predict);
    sb_pop("b_ghr_recover", b_fetch_ghr);
    tick();
    drive_b_mem(32'h104, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
    settle(); tick();
    b_mem_branch = 0;
    sb_push(32'h1); sb_push(32'h0); sb_push(32'h1);
    settle();
    sb_pop("b_ghr_set", b_fetch_ghr);
    sb_pop("b_history_ignored", b_fetch_predict);
    sb_pop("b_hit2", b_fetch_hit);
    tick();
    b_fetch_valid = 1; b_fetch_pc = 32'h104;
    sb_push(32'h1);
    settle(); sb_pop("b_pred_104", b_fetch_predict); tick();
    b_fetch_pc = 32'h100;
    sb_push(32'h1);
    settle(); sb_pop("b_ghr_shift1", b_fetch_ghr); tick();
    b_fetch_valid = 0;
    sb_push(32'h0);
    settle(); sb_pop("b_ghr_shift0", b_fetch_ghr); tick();

    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
